// File: rtl/env_pass_scheduler.sv
// rtl/env_pass_scheduler.sv - frame-tick pass sequencer for the environment manager
// Issues one start per accepted tick, forwards indexed vertices, tracks pass stats and a watchdog.
module env_pass_scheduler #(
   parameter int WORLD_BITS     = 32,
   parameter int MAX_POINTS     = 256,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_BITS       = 8
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          frame_tick_in,
   input  logic                          pause_in,
   output logic                          env_start_out,
   input  logic                          env_valid_in,
   input  logic [WORLD_BITS-1:0]         env_x_in,
   input  logic [WORLD_BITS-1:0]         env_y_in,
   input  logic                          env_done_in,
   output logic                          pt_valid_out,
   output logic [WORLD_BITS-1:0]         pt_x_out,
   output logic [WORLD_BITS-1:0]         pt_y_out,
   output logic [$clog2(MAX_POINTS)-1:0] pt_index_out,
   output logic                          pass_busy_out,
   output logic                          pass_done_out,
   output logic [$clog2(MAX_POINTS):0]   point_count_out,
   output logic [CNT_BITS-1:0]           overrun_count_out,
   output logic                          timeout_out
);

   localparam int IDX_W = $clog2(MAX_POINTS);
   localparam int CW    = IDX_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DRAIN} state_t;

   state_t                state_q;
   logic                  pending_q;
   logic [CW-1:0]         cnt_q;
   logic [WD_W-1:0]       wd_q;
   logic [WD_W-1:0]       wd_d;
   logic                  start_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  timeout_q;
   logic                  pt_valid_q;
   logic [WORLD_BITS-1:0] pt_x_q;
   logic [WORLD_BITS-1:0] pt_y_q;
   logic [IDX_W-1:0]      pt_idx_q;
   logic [CW-1:0]         pcount_q;
   logic [CNT_BITS-1:0]   ovr_q;

   logic in_run;
   logic vtx_take;
   logic wd_expire;
   logic can_start;

   always_comb begin
      in_run    = (state_q == S_RUN);
      vtx_take  = in_run && env_valid_in && (cnt_q < CW'(MAX_POINTS));
      wd_d      = wd_q + 1'b1;
      // Expiry is judged on the incremented value so the flag lands TIMEOUT_CYCLES after start.
      wd_expire = in_run && !env_done_in && (wd_d == WD_W'(TIMEOUT_CYCLES - 1));
      can_start = (state_q == S_IDLE) && (frame_tick_in || pending_q) && !pause_in;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         pending_q  <= 1'b0;
         cnt_q      <= '0;
         wd_q       <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         pt_valid_q <= 1'b0;
         pt_x_q     <= '0;
         pt_y_q     <= '0;
         pt_idx_q   <= '0;
         pcount_q   <= '0;
         ovr_q      <= '0;
      end else begin
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         pt_valid_q <= vtx_take;

         if (vtx_take) begin
            pt_x_q   <= env_x_in;
            pt_y_q   <= env_y_in;
            pt_idx_q <= cnt_q[IDX_W-1:0];
            cnt_q    <= cnt_q + 1'b1;
         end

         // Only one tick is ever queued; surplus ticks are counted as overruns.
         if (can_start) begin
            pending_q <= 1'b0;
         end else if (frame_tick_in) begin
            if (!pending_q) begin
               pending_q <= 1'b1;
            end else if (!(&ovr_q)) begin
               ovr_q <= ovr_q + 1'b1;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (can_start) begin
                  state_q <= S_START;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  wd_q    <= '0;
               end
            end
            S_START: begin
               state_q <= S_RUN;
            end
            S_RUN: begin
               wd_q <= wd_d;
               if (env_done_in) begin
                  pcount_q <= cnt_q + CW'(vtx_take);
                  done_q   <= 1'b1;
                  state_q  <= S_DRAIN;
               end else if (wd_expire) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            S_DRAIN: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign env_start_out     = start_q;
   assign pass_busy_out     = busy_q;
   assign pass_done_out     = done_q;
   assign timeout_out       = timeout_q;
   assign pt_valid_out      = pt_valid_q;
   assign pt_x_out          = pt_x_q;
   assign pt_y_out          = pt_y_q;
   assign pt_index_out      = pt_idx_q;
   assign point_count_out   = pcount_q;
   assign overrun_count_out = ovr_q;

endmodule

// File: doc/env_pass_scheduler.md
Name: env_pass_scheduler

Overview:
Frame-level sequencer for the environment manager.
- On each frame tick it issues a single-cycle start to the environment manager.
- It forwards the resulting vertex stream to downstream consumers (renderer, collision), tagged with a running vertex index.
- It records per-pass statistics and tracks pending ticks and overruns.
- A watchdog catches a pass that never signals done. Moving obstacles therefore advance exactly once per accepted tick.

Parameters:
WORLD_BITS, 32, width of world coordinates on env_x_in/env_y_in and pt_x_out/pt_y_out
MAX_POINTS, 256, maximum vertices per pass; sizes pt_index_out and point_count_out
TIMEOUT_CYCLES, 4096, cycles allowed from env_start_out to env_done_in before the pass is aborted
CNT_BITS, 8, width of overrun_count_out (saturating)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
frame_tick_in  input  1  one-cycle pulse per frame (vsync-derived)
pause_in  input  1  level; while high, ticks are not accepted
env_start_out  output  1  one-cycle start pulse to the environment manager
env_valid_in  input  1  vertex valid from the environment manager
env_x_in  input  WORLD_BITS  vertex x
env_y_in  input  WORLD_BITS  vertex y
env_done_in  input  1  pass-complete pulse from the environment manager
pt_valid_out  output  1  forwarded vertex valid
pt_x_out  output  WORLD_BITS  forwarded x
pt_y_out  output  WORLD_BITS  forwarded y
pt_index_out  output  $clog2(MAX_POINTS)  0-based vertex index within the pass
pass_busy_out  output  1  high from the start pulse until the pass completes or aborts
pass_done_out  output  1  one-cycle pulse when a pass completes normally
point_count_out  output  $clog2(MAX_POINTS)+1  vertex count of the last completed pass
overrun_count_out  output  CNT_BITS  saturating count of dropped ticks
timeout_out  output  1  sticky flag: a pass has timed out

Behaviour:
Reset (asynchronous, rst_in high):
- All outputs go to 0.
- State goes to IDLE; the pending flag, vertex counter and watchdog clear.
- Asserting reset mid-pass aborts immediately. env_valid_in/env_done_in arriving after reset release while in IDLE are ignored.

State machine: IDLE, START, RUN, DRAIN.
- IDLE: accepts a tick when (frame_tick_in or pending) and !pause_in, then goes to START.
  - pending clears when consumed.
  - pause does not discard a pending tick; it holds it until pause drops.
- START: env_start_out=1 for exactly one cycle; pass_busy_out=1; vertex counter=0; watchdog=0. Next state RUN.
  - env_start_out is registered, so it appears the cycle after tick acceptance (tick at cycle N -> start at N+1).
- RUN, each cycle:
  - Watchdog increments.
  - If env_valid_in: pt_valid_out=1 next cycle, with pt_x_out/pt_y_out/pt_index_out registered from the inputs and counter. This is 1-cycle latency with no backpressure; consumers must accept every beat. The counter then increments.
  - If the counter is already MAX_POINTS, the vertex is dropped and the counter saturates.
  - If env_done_in: point_count_out<=counter (including a vertex accepted in the same cycle); next state DRAIN.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without done: set timeout_out; point_count_out is unchanged; no pass_done_out; pass_busy_out<=0; state IDLE.
- DRAIN: pass_done_out=1 for one cycle; pass_busy_out<=0; state IDLE. The last pt_valid_out beat always precedes or coincides with DRAIN, never follows pass_done_out.

Tick handling while not IDLE (START/RUN/DRAIN):
- The first tick sets pending.
- Any further tick while pending is set increments overrun_count_out, saturating at 2^CNT_BITS-1.
- At most one tick is ever queued.

Simultaneous events:
- Tick in the same cycle as env_done_in: the tick becomes pending.
- Tick in the same cycle as a timeout: the tick becomes pending.
- Tick while pause_in is high in IDLE: it sets pending and does not start.

Outside RUN, env_valid_in and env_done_in are ignored and pt_valid_out stays 0. timeout_out clears only on reset.

Test Plan:
1. Reset, tick at cycle 10 -> env_start_out high at cycle 11 only; pass_busy_out high from 11. Model emits 5 vertices then done -> pt_index_out 0..4 each 1 cycle after the input; point_count_out=5; one pass_done_out pulse; busy drops.
2. Tick mid-pass, then 2 more ticks before done -> after done, a second start pulse follows from pending; overrun_count_out=2.
3. Model never asserts done, TIMEOUT_CYCLES=64 -> timeout_out=1 at start+64; no pass_done_out; busy=0; the next tick starts a new pass normally.
4. pause_in high, tick arrives -> no start; drop pause 20 cycles later -> start pulse the cycle after pause drops; overrun_count_out=0.
5. MAX_POINTS=4, model emits 6 vertices -> only indices 0..3 forwarded; point_count_out=4.
6. Assert rst_in asynchronously during RUN with a vertex in flight -> all outputs 0 immediately; subsequent stray env_valid_in/env_done_in produce no pt_valid_out or pass_done_out.
